// File: rtl/ascon_perm_scheduler.sv
// ascon_perm_scheduler: round controller for the ASCON permutation datapath.
// Sequences IDLE -> LOAD -> ROUND x R -> DONE and Moore-decodes the state
// register controls, round index and round constant.
// Optional build macro ASCON_PERM_ABORT_EN adds an abort_i input that
// cancels a running permutation without a done pulse.
module ascon_perm_scheduler #(
    parameter int ROUNDS_A = 12,
    parameter int ROUNDS_B = 6,
    parameter int RW       = 4
) (
    input  logic          clock_i,
    input  logic          resetb_i,
    input  logic          start_i,
    input  logic          mode_i,
`ifdef ASCON_PERM_ABORT_EN
    input  logic          abort_i,
`endif
    output logic          ready_o,
    output logic          busy_o,
    output logic          sel_init_o,
    output logic          en_state_o,
    output logic [RW-1:0] round_o,
    output logic [7:0]    round_const_o,
    output logic          done_o
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] ROUND = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    // Round constant: upper nibble 0xF - r, lower nibble r; no wrap for r <= 11.
    function automatic logic [7:0] round_constant(input logic [3:0] r);
        logic [3:0] hi;
        hi = 4'hF - r;
        return {hi, r};
    endfunction

    logic [1:0]    state_q;
    logic [1:0]    state_d;
    logic [RW-1:0] cnt_q;
    logic [RW-1:0] cnt_d;
    logic          abort;
    logic [3:0]    r4;

`ifdef ASCON_PERM_ABORT_EN
    assign abort = abort_i;
`else
    assign abort = 1'b0;
`endif

    assign r4 = 4'(cnt_q);

    // Next-state and counter logic; mode_i only seeds the counter on accept,
    // so later changes cannot alter the running permutation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = LOAD;
                    cnt_d   = mode_i ? RW'(ROUNDS_A - ROUNDS_B) : '0;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                if (abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == RW'(ROUNDS_A - 1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + RW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and round counter registers with synchronous active-low reset.
    always_ff @(posedge clock_i) begin
        if (!resetb_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Moore output decode; abort only gates the state write enable.
    always_comb begin
        ready_o       = 1'b0;
        busy_o        = 1'b0;
        sel_init_o    = 1'b0;
        en_state_o    = 1'b0;
        round_o       = '0;
        round_const_o = 8'h00;
        done_o        = 1'b0;
        case (state_q)
            IDLE: begin
                ready_o = 1'b1;
            end
            LOAD: begin
                busy_o     = 1'b1;
                sel_init_o = 1'b1;
                en_state_o = ~abort;
            end
            ROUND: begin
                busy_o        = 1'b1;
                en_state_o    = ~abort;
                round_o       = cnt_q;
                round_const_o = round_constant(r4);
            end
            default: begin
                done_o = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_ascon_perm_scheduler.sv
// tb_ascon_perm_scheduler: directed bench for ascon_perm_scheduler.
// Inputs change 1 time unit after the rising edge; outputs are checked there.
module tb_ascon_perm_scheduler;

    logic       clock_i = 1'b0;
    logic       resetb_i;
    logic       start_i;
    logic       mode_i;
`ifdef ASCON_PERM_ABORT_EN
    logic       abort_i;
`endif
    logic       ready_o;
    logic       busy_o;
    logic       sel_init_o;
    logic       en_state_o;
    logic [3:0] round_o;
    logic [7:0] round_const_o;
    logic       done_o;

    int errors = 0;
    int checks = 0;

    logic [7:0] rc_tab [12] = '{8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
                                8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B};

    ascon_perm_scheduler dut (
        .clock_i       (clock_i),
        .resetb_i      (resetb_i),
        .start_i       (start_i),
        .mode_i        (mode_i),
`ifdef ASCON_PERM_ABORT_EN
        .abort_i       (abort_i),
`endif
        .ready_o       (ready_o),
        .busy_o        (busy_o),
        .sel_init_o    (sel_init_o),
        .en_state_o    (en_state_o),
        .round_o       (round_o),
        .round_const_o (round_const_o),
        .done_o        (done_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic step();
        @(posedge clock_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ready"}, 32'(ready_o), 32'd1);
        chk({tag, "_busy"},  32'(busy_o), 32'd0);
        chk({tag, "_sel"},   32'(sel_init_o), 32'd0);
        chk({tag, "_en"},    32'(en_state_o), 32'd0);
        chk({tag, "_done"},  32'(done_o), 32'd0);
        chk({tag, "_round"}, 32'(round_o), 32'd0);
        chk({tag, "_rc"},    32'(round_const_o), 32'h00);
    endtask

    initial begin
        int loads;
        int dones;
        int badpos;
        int done_k;
        int en_cnt;
        resetb_i = 1'b0;
        start_i  = 1'b0;
        mode_i   = 1'b0;
`ifdef ASCON_PERM_ABORT_EN
        abort_i  = 1'b0;
`endif
        // Reset for two edges.
        step();
        step();
        chk_idle("reset");
        resetb_i = 1'b1;
        step();

        // p12: accept at edge T, LOAD at T+1, rounds T+2..T+13, done T+14.
        start_i = 1'b1;
        mode_i  = 1'b0;
        step();
        start_i = 1'b0;
        chk("p12_load_sel", 32'(sel_init_o), 32'd1);
        chk("p12_load_en", 32'(en_state_o), 32'd1);
        chk("p12_load_busy", 32'(busy_o), 32'd1);
        chk("p12_load_ready", 32'(ready_o), 32'd0);
        for (int i = 0; i < 12; i++) begin
            step();
            chk($sformatf("p12_round%0d", i), 32'(round_o), 32'(i));
            chk($sformatf("p12_rc%0d", i), 32'(round_const_o), 32'(rc_tab[i]));
            chk($sformatf("p12_en%0d", i), 32'(en_state_o & ~sel_init_o & ~done_o), 32'd1);
        end
        step();
        chk("p12_done", 32'(done_o), 32'd1);
        chk("p12_done_en", 32'(en_state_o), 32'd0);
        chk("p12_done_ready", 32'(ready_o), 32'd0);
        step();
        chk("p12_after_ready", 32'(ready_o), 32'd1);
        chk("p12_after_done", 32'(done_o), 32'd0);

        // p6: rounds 6..11, en_state_o high 7 cycles, done at T+8.
        start_i = 1'b1;
        mode_i  = 1'b1;
        step();
        start_i = 1'b0;
        mode_i  = 1'b0;
        en_cnt  = 0;
        done_k  = 0;
        chk("p6_load_sel", 32'(sel_init_o), 32'd1);
        if (en_state_o) en_cnt++;
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("p6_round%0d", i), 32'(round_o), 32'(i + 6));
            chk($sformatf("p6_rc%0d", i), 32'(round_const_o), 32'(rc_tab[i + 6]));
            if (en_state_o) en_cnt++;
        end
        for (int k = 8; k <= 10; k++) begin
            step();
            if (en_state_o) en_cnt++;
            if (done_o && done_k == 0) done_k = k;
        end
        chk("p6_en_cycles", 32'(en_cnt), 32'd7);
        chk("p6_done_cycle", 32'(done_k), 32'd8);

        // start_i held high: accepts at T, T+15, T+30; done at T+14, T+29, T+44.
        start_i = 1'b1;
        mode_i  = 1'b0;
        loads   = 0;
        dones   = 0;
        badpos  = 0;
        for (int k = 1; k <= 44; k++) begin
            step();
            if (sel_init_o) begin
                loads++;
                if (k != 1 && k != 16 && k != 31) badpos++;
            end
            if (done_o) begin
                dones++;
                if (k != 14 && k != 29 && k != 44) badpos++;
            end
            if (k == 44) start_i = 1'b0;
        end
        chk("hold_loads", 32'(loads), 32'd3);
        chk("hold_dones", 32'(dones), 32'd3);
        chk("hold_positions", 32'(badpos), 32'd0);
        step();
        chk("hold_idle_ready", 32'(ready_o), 32'd1);

        // mode_i toggled 0 -> 1 at T+3 of a p12 run: still done at T+14.
        start_i = 1'b1;
        mode_i  = 1'b0;
        step();
        start_i = 1'b0;
        done_k  = 0;
        for (int k = 2; k <= 16; k++) begin
            step();
            if (k == 3) mode_i = 1'b1;
            if (done_o && done_k == 0) done_k = k;
        end
        mode_i = 1'b0;
        chk("toggle_done_cycle", 32'(done_k), 32'd14);

        // Synchronous reset at round 5 of p12: IDLE next cycle, no done pulse.
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int k = 0; k < 20 && round_o != 4'd5; k++) step();
        chk("rst_mid_round", 32'(round_o), 32'd5);
        resetb_i = 1'b0;
        step();
        resetb_i = 1'b1;
        chk_idle("rst_mid");
        dones = 0;
        for (int k = 0; k < 15; k++) begin
            step();
            if (done_o) dones++;
        end
        chk("rst_mid_nodone", 32'(dones), 32'd0);

`ifdef ASCON_PERM_ABORT_EN
        // Abort at round 3: en_state_o low that cycle, IDLE next, no done.
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int k = 0; k < 20 && round_o != 4'd3; k++) step();
        abort_i = 1'b1;
        #1;
        chk("abort_round", 32'(round_o), 32'd3);
        chk("abort_en", 32'(en_state_o), 32'd0);
        step();
        abort_i = 1'b0;
        chk("abort_ready", 32'(ready_o), 32'd1);
        dones = 0;
        for (int k = 0; k < 15; k++) begin
            step();
            if (done_o) dones++;
        end
        chk("abort_nodone", 32'(dones), 32'd0);
        start_i = 1'b1;
        mode_i  = 1'b1;
        step();
        start_i = 1'b0;
        mode_i  = 1'b0;
        done_k  = 0;
        for (int k = 2; k <= 10; k++) begin
            step();
            if (done_o && done_k == 0) done_k = k;
        end
        chk("abort_p6_done", 32'(done_k), 32'd8);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ascon_perm_scheduler.md
Name: ascon_perm_scheduler

Overview:
Round controller for the ASCON permutation datapath: constant addition, then the 64-column sbox substitution layer, then linear diffusion, closing into a 320-bit state register.
- Accepts a permutation request for p12 (initialisation/finalisation) or p6 (data processing).
- Drives the state-register load mux and write enable, and supplies the round index and round constant each cycle.
- Pulses done when the permuted state is valid in the register.
- Sits between the ASCON mode FSM (requester) and the round datapath.

Parameters:
ROUNDS_A, 12, rounds for p^a (mode_i=0)
ROUNDS_B, 6, rounds for p^b (mode_i=1); must be ≤ ROUNDS_A
RW, 4, round counter width; must hold ROUNDS_A-1

Ports:
clock_i  in  1  single clock, rising edge
resetb_i  in  1  synchronous reset, active-low
start_i  in  1  permutation request; accepted only when ready_o=1
mode_i  in  1  0 = p^a (12 rounds), 1 = p^b (6 rounds); sampled on accept only
ready_o  out  1  scheduler idle, can accept start_i
busy_o  out  1  permutation in progress (LOAD or ROUND)
sel_init_o  out  1  1 = state register loads external input state; 0 = loads round output
en_state_o  out  1  state register write enable
round_o  out  RW  current global round index r (0..ROUNDS_A-1)
round_const_o  out  8  round constant {(4'hF - r), r[3:0]}
done_o  out  1  one-cycle pulse, permuted state valid in register

Behaviour:
- Clock and reset: one clock, clock_i. resetb_i is synchronous and active-low; sampled low on a rising edge it forces state IDLE and counter 0, from any state including mid-permutation.
- Reset output values (IDLE decode): ready_o=1; busy_o, sel_init_o, en_state_o, done_o = 0; round_o=0; round_const_o=8'h00.
- Outputs are Moore-decoded from the registered FSM state and counter.
- FSM states: IDLE, LOAD, ROUND, DONE.
- IDLE: ready_o=1.
  - start_i=1 → LOAD.
  - Capture mode_i.
  - Counter ← ROUNDS_A-ROUNDS_B if mode_i=1, else 0.
- LOAD (1 cycle): sel_init_o=1, en_state_o=1, busy_o=1 → ROUND.
- ROUND: en_state_o=1, sel_init_o=0, busy_o=1.
  - round_o = counter; round_const_o = {4'hF-counter, counter}.
  - Counter increments each cycle.
  - When counter == ROUNDS_A-1 → DONE, counter ← 0.
- DONE (1 cycle): done_o=1, ready_o=0, en_state_o=0 → IDLE.
- Latency: with accept at edge T, LOAD is cycle T+1, ROUND occupies cycles T+2..T+1+R, done_o is high in cycle T+2+R. That is 14 cycles for p12 and 8 for p6.
- Constant width: upper nibble computed in 4 bits, no wrap for r ≤ 11. Examples: r=0 → 8'hF0, r=6 → 8'h96, r=11 → 8'h4B.
- start_i while ready_o=0 (LOAD/ROUND/DONE): ignored, not queued. Requester must hold or re-assert it.
- mode_i changes after accept: no effect on the running permutation.
- Back-to-back: earliest next accept is the first IDLE cycle after DONE, i.e. one idle cycle minimum between permutations.
- en_state_o never asserted in IDLE or DONE, so the result stays stable in the register until the next LOAD.

Optional Feature:
- Macro ASCON_PERM_ABORT_EN.
- When defined:
  - Adds input port abort_i (1 bit).
  - abort_i=1 in LOAD or ROUND forces en_state_o=0 that cycle, next state IDLE, counter ← 0.
  - done_o is not pulsed.
  - abort_i is ignored in IDLE and DONE; in DONE, done_o still pulses.
  - If abort_i and start_i are both high in IDLE, start is accepted.
- When undefined: no abort_i port; a permutation always runs to completion unless resetb_i is asserted.

Test Plan:
- p12: resetb_i=0 for 2 cycles then 1; start_i=1, mode_i=0 for 1 cycle at T.
  - Expect sel_init_o=1 at T+1.
  - round_o 0..11 at T+2..T+13, round_const_o F0,E1,D2,...,4B.
  - done_o=1 only at T+14; ready_o=1 at T+15.
- p6: start_i=1, mode_i=1.
  - Expect round_o 6..11 and round_const_o 96,87,78,69,5A,4B.
  - en_state_o high for 7 cycles total; done_o at T+8.
- start_i held high continuously with mode_i=0.
  - Expect accepts at T, T+15, T+30, each producing exactly one done_o.
  - Start pulses during busy are not queued.
- mode_i toggled 0→1 at T+3 of a p12 run: still 12 rounds, done_o at T+14.
- resetb_i=0 at round_o=5 of p12.
  - Next cycle: IDLE, ready_o=1, en_state_o=0, round_const_o=00.
  - No done_o pulse.
- ASCON_PERM_ABORT_EN defined: abort_i=1 at round_o=3.
  - Expect en_state_o=0 that cycle, ready_o=1 next cycle, no done_o.
  - A fresh p6 start then completes normally with done_o 8 cycles after accept.
